// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg -- shared definitions for the instruction memory block.
//
// Contents:
//   imem_state_t  controller state encoding (CLEAR, RUN, LOAD)
//   IMEM_DATA_W   default instruction word width in bits
//   IMEM_DEPTH    default number of words
//   IMEM_ADDR_W   default byte-address width
//
// Optional feature macro used by the block: IMEM_PARITY_EN
// -----------------------------------------------------------------------------
package imem_pkg;

   localparam int IMEM_DATA_W = 32;
   localparam int IMEM_DEPTH  = 256;
   localparam int IMEM_ADDR_W = 32;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_RUN   = 2'd1,
      ST_LOAD  = 2'd2
   } imem_state_t;

endpackage : imem_pkg

// File: rtl/imem_ram.sv
// -----------------------------------------------------------------------------
// imem_ram -- word-organised storage array for instr_mem.
//
// One write port with per-byte enables and one synchronous read port
// (read data appears the cycle after re is sampled and then holds until
// the next read).
//
// Ports:
//   clk     in   clock, all state on rising edge
//   we      in   write strobe
//   waddr   in   write word index
//   wdata   in   write data
//   wbe     in   write byte enables
//   wpar    in   per-byte parity bits to store      (IMEM_PARITY_EN only)
//   re      in   read strobe
//   raddr   in   read word index
//   rdata   out  registered read data
//   rpar    out  registered per-byte parity bits    (IMEM_PARITY_EN only)
//
// Build option: define IMEM_PARITY_EN to add one stored parity bit per byte.
// -----------------------------------------------------------------------------
module imem_ram
   import imem_pkg::*;
#(
   parameter  int DATA_W = IMEM_DATA_W,
   parameter  int DEPTH  = IMEM_DEPTH,
   localparam int IDX_W  = $clog2(DEPTH),
   localparam int NB     = DATA_W / 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [NB-1:0]     wbe,
`ifdef IMEM_PARITY_EN
   input  logic [NB-1:0]     wpar,
`endif
   input  logic              re,
   input  logic [IDX_W-1:0]  raddr,
`ifdef IMEM_PARITY_EN
   output logic [NB-1:0]     rpar,
`endif
   output logic [DATA_W-1:0] rdata
);

   // NOTE: the array has no reset; the controller scrubs it through the write
   // port after every reset, so the storage can map onto plain RAM macros.
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < NB; b++) begin
            if (wbe[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
      if (re) rdata_q <= mem[raddr];
   end

   assign rdata = rdata_q;

`ifdef IMEM_PARITY_EN
   logic [NB-1:0] par_mem [DEPTH];
   logic [NB-1:0] rpar_q;

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < NB; b++) begin
            if (wbe[b]) par_mem[waddr][b] <= wpar[b];
         end
      end
      if (re) rpar_q <= par_mem[raddr];
   end

   assign rpar = rpar_q;
`endif

endmodule : imem_ram

// File: rtl/instr_mem.sv
// -----------------------------------------------------------------------------
// instr_mem -- loadable instruction memory with a fetch port.
//
// After reset the controller scrubs every word to zero (CLEAR, DEPTH cycles),
// then serves fetches (RUN). Holding load_en moves it to LOAD, where byte-
// masked writes fill the array; dropping load_en returns it to RUN.
//
// Ports:
//   clk          in   clock, all state on rising edge
//   reset        in   asynchronous, active-high reset
//   load_en      in   level request for load mode
//   ld_we        in   load write strobe
//   ld_addr      in   load byte address (word aligned, in range)
//   ld_data      in   load write data
//   ld_be        in   load byte enables
//   fetch_req    in   fetch request
//   fetch_addr   in   fetch byte address
//   fetch_ready  out  request accepted when high with fetch_req (RUN only)
//   fetch_valid  out  one-cycle response strobe, latency 1 after acceptance
//   fetch_data   out  fetched word; zero on error, holds while not valid
//   fetch_err    out  response error: misaligned, out of range, or parity
//   busy         out  high in CLEAR or LOAD
//
// Build option: define IMEM_PARITY_EN to store and check even parity per
// byte; without it fetch_err reports address errors only.
// -----------------------------------------------------------------------------
module instr_mem
   import imem_pkg::*;
#(
   parameter int DATA_W = IMEM_DATA_W,
   parameter int DEPTH  = IMEM_DEPTH,
   parameter int ADDR_W = IMEM_ADDR_W
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                load_en,
   input  logic                ld_we,
   input  logic [ADDR_W-1:0]   ld_addr,
   input  logic [DATA_W-1:0]   ld_data,
   input  logic [DATA_W/8-1:0] ld_be,
   input  logic                fetch_req,
   input  logic [ADDR_W-1:0]   fetch_addr,
   output logic                fetch_ready,
   output logic                fetch_valid,
   output logic [DATA_W-1:0]   fetch_data,
   output logic                fetch_err,
   output logic                busy
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int NB    = DATA_W / 8;

   imem_state_t       state_q, state_d;
   logic [IDX_W-1:0]  clr_cnt_q, clr_cnt_d;
   logic              fetch_valid_q, fetch_valid_d;
   logic              addr_err_q, addr_err_d;
   logic [DATA_W-1:0] fetch_data_q, fetch_data_d;

   logic              ram_we;
   logic [IDX_W-1:0]  ram_waddr;
   logic [DATA_W-1:0] ram_wdata;
   logic [NB-1:0]     ram_wbe;
   logic [DATA_W-1:0] ram_rdata;

   logic              ld_addr_ok;
   logic              fetch_accept;
   logic              fetch_addr_bad;
   logic              par_err;
   logic              resp_err;
   logic [DATA_W-1:0] resp_data;

   // A byte address is usable only when word aligned and below DEPTH*4, i.e.
   // every bit above the word index is zero.
   assign ld_addr_ok     = (ld_addr[1:0] == 2'b00) && !(|ld_addr[ADDR_W-1:IDX_W+2]);
   assign fetch_addr_bad = (fetch_addr[1:0] != 2'b00) || (|fetch_addr[ADDR_W-1:IDX_W+2]);
   assign fetch_accept   = fetch_req && (state_q == ST_RUN);

   // NOTE: every always_comb output gets a default before the case so no
   // path leaves a signal unassigned (which would infer a latch).
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      ram_we    = 1'b0;
      ram_waddr = clr_cnt_q;
      ram_wdata = '0;
      ram_wbe   = '0;
      unique case (state_q)
         ST_CLEAR: begin
            // Scrub one word per cycle; load_en has no effect until RUN.
            ram_we    = 1'b1;
            ram_wbe   = '1;
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == IDX_W'(DEPTH - 1)) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (load_en) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            if (!load_en) state_d = ST_RUN;
            ram_we    = ld_we && ld_addr_ok;
            ram_waddr = ld_addr[IDX_W+1:2];
            ram_wdata = ld_data;
            ram_wbe   = ld_be;
         end
         default: state_d = ST_CLEAR;
      endcase
   end

`ifdef IMEM_PARITY_EN
   logic [NB-1:0] ram_wpar;
   logic [NB-1:0] ram_rpar;
   logic [NB-1:0] rd_par_calc;

   // Scrub data is zero, so its even parity is zero as well.
   always_comb begin
      ram_wpar    = '0;
      rd_par_calc = '0;
      for (int b = 0; b < NB; b++) begin
         ram_wpar[b]    = ^ram_wdata[b*8 +: 8];
         rd_par_calc[b] = ^ram_rdata[b*8 +: 8];
      end
   end

   assign par_err = |(rd_par_calc ^ ram_rpar);
`else
   assign par_err = 1'b0;
`endif

   imem_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .wbe   (ram_wbe),
`ifdef IMEM_PARITY_EN
      .wpar  (ram_wpar),
      .rpar  (ram_rpar),
`endif
      .re    (fetch_accept),
      .raddr (fetch_addr[IDX_W+1:2]),
      .rdata (ram_rdata)
   );

   // Response is formed in the cycle after acceptance from the RAM's
   // registered read data; errors force the word to zero.
   assign resp_err      = addr_err_q || par_err;
   assign resp_data     = resp_err ? '0 : ram_rdata;
   assign fetch_valid_d = fetch_accept;
   assign addr_err_d    = fetch_accept && fetch_addr_bad;
   assign fetch_data_d  = fetch_valid_q ? resp_data : fetch_data_q;

   // NOTE: sequential state uses non-blocking assignments so all flops sample
   // their _d values from the same pre-edge snapshot.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_CLEAR;
         clr_cnt_q     <= '0;
         fetch_valid_q <= 1'b0;
         addr_err_q    <= 1'b0;
         fetch_data_q  <= '0;
      end else begin
         state_q       <= state_d;
         clr_cnt_q     <= clr_cnt_d;
         fetch_valid_q <= fetch_valid_d;
         addr_err_q    <= addr_err_d;
         fetch_data_q  <= fetch_data_d;
      end
   end

   assign fetch_ready = (state_q == ST_RUN);
   assign busy        = (state_q != ST_RUN);
   assign fetch_valid = fetch_valid_q;
   assign fetch_err   = fetch_valid_q && resp_err;
   assign fetch_data  = fetch_data_d;

endmodule : instr_mem

// File: tb/tb_instr_mem.sv
// -----------------------------------------------------------------------------
// tb_instr_mem -- directed self-checking bench for instr_mem (default
// parameters: 32-bit words, 256 words, 32-bit byte addresses).
// With IMEM_PARITY_EN defined an extra parity-corruption step is included.
// -----------------------------------------------------------------------------
module tb_instr_mem;

   logic        clk = 1'b0;
   logic        reset;
   logic        load_en;
   logic        ld_we;
   logic [31:0] ld_addr;
   logic [31:0] ld_data;
   logic [3:0]  ld_be;
   logic        fetch_req;
   logic [31:0] fetch_addr;
   logic        fetch_ready;
   logic        fetch_valid;
   logic [31:0] fetch_data;
   logic        fetch_err;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   instr_mem #(
      .DATA_W (32),
      .DEPTH  (256),
      .ADDR_W (32)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .load_en     (load_en),
      .ld_we       (ld_we),
      .ld_addr     (ld_addr),
      .ld_data     (ld_data),
      .ld_be       (ld_be),
      .fetch_req   (fetch_req),
      .fetch_addr  (fetch_addr),
      .fetch_ready (fetch_ready),
      .fetch_valid (fetch_valid),
      .fetch_data  (fetch_data),
      .fetch_err   (fetch_err),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #200_000;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 1 time unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Count rising edges while busy stays high (bounded).
   task automatic count_busy(output int n);
      n = 0;
      while (busy && n < 1000) begin
         step();
         n++;
      end
   endtask

   task automatic ld_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
      ld_we   = 1'b1;
      ld_addr = addr;
      ld_data = data;
      ld_be   = be;
      step();
      ld_we   = 1'b0;
   endtask

   task automatic do_fetch(input string tag, input logic [31:0] addr,
                           input logic [31:0] exp_data, input logic exp_err);
      fetch_req  = 1'b1;
      fetch_addr = addr;
      step();
      fetch_req  = 1'b0;
      check({tag, "_valid"}, 32'(fetch_valid), 32'd1);
      check({tag, "_data"},  fetch_data, exp_data);
      check({tag, "_err"},   32'(fetch_err), 32'(exp_err));
   endtask

   initial begin
      int n_busy;

      reset      = 1'b1;
      load_en    = 1'b0;
      ld_we      = 1'b0;
      ld_addr    = '0;
      ld_data    = '0;
      ld_be      = '0;
      fetch_req  = 1'b0;
      fetch_addr = '0;
      step();
      step();

      // Reset state.
      check("rst_busy",  32'(busy),        32'd1);
      check("rst_ready", 32'(fetch_ready), 32'd0);
      check("rst_valid", 32'(fetch_valid), 32'd0);
      check("rst_err",   32'(fetch_err),   32'd0);
      check("rst_data",  fetch_data,       32'd0);

      // Release reset with load_en held high: CLEAR must ignore it and last 256 cycles.
      reset   = 1'b0;
      load_en = 1'b1;
      count_busy(n_busy);
      check("clear_len", 32'(n_busy), 32'd256);
      check("run_ready", 32'(fetch_ready), 32'd1);
      load_en = 1'b0;

      do_fetch("fetch0", 32'h0, 32'h0, 1'b0);
      step();
      check("idle_valid", 32'(fetch_valid), 32'd0);

      // Load mode: full word, then a single low byte, then dropped writes.
      load_en = 1'b1;
      step();
      check("load_busy",  32'(busy),        32'd1);
      check("load_ready", 32'(fetch_ready), 32'd0);
      ld_write(32'h10,  32'hDEADBEEF, 4'b1111);
      ld_write(32'h10,  32'h00000011, 4'b0001);
      ld_write(32'h12,  32'hFFFFFFFF, 4'b1111);  // misaligned: dropped
      ld_write(32'h414, 32'hFFFFFFFF, 4'b1111);  // aliases 0x14 if not dropped
      ld_write(32'h4,   32'hA5A5A5A5, 4'b1111);
      ld_write(32'h8,   32'h0BADF00D, 4'b1111);
      ld_write(32'hC,   32'hCAFEF00D, 4'b1111);
      ld_write(32'h24,  32'h00000000, 4'b1111);
      ld_write(32'h24,  32'h00AB0000, 4'b0100);
      load_en = 1'b0;
      step();
      check("run_again", 32'(busy), 32'd0);

      // Write strobe in RUN must be ignored.
      ld_write(32'h18, 32'hFFFFFFFF, 4'b1111);

      do_fetch("be_merge", 32'h10, 32'hDEADBE11, 1'b0);
      step();
      check("hold_valid", 32'(fetch_valid), 32'd0);
      check("hold_data",  fetch_data,       32'hDEADBE11);
      do_fetch("oor_drop",  32'h14, 32'h0,        1'b0);
      do_fetch("run_we",    32'h18, 32'h0,        1'b0);
      do_fetch("byte2",     32'h24, 32'h00AB0000, 1'b0);
      do_fetch("misalign",  32'h3,  32'h0,        1'b1);
      do_fetch("range",     32'h400, 32'h0,       1'b1);

      // Back-to-back fetches: four consecutive responses in order.
      fetch_req  = 1'b1;
      fetch_addr = 32'h0;
      step();
      check("b2b0_valid", 32'(fetch_valid), 32'd1);
      check("b2b0_data",  fetch_data, 32'h00000000);
      fetch_addr = 32'h4;
      step();
      check("b2b1_valid", 32'(fetch_valid), 32'd1);
      check("b2b1_data",  fetch_data, 32'hA5A5A5A5);
      fetch_addr = 32'h8;
      step();
      check("b2b2_valid", 32'(fetch_valid), 32'd1);
      check("b2b2_data",  fetch_data, 32'h0BADF00D);
      fetch_addr = 32'hC;
      step();
      check("b2b3_valid", 32'(fetch_valid), 32'd1);
      check("b2b3_data",  fetch_data, 32'hCAFEF00D);
      fetch_req = 1'b0;
      step();
      check("b2b_end", 32'(fetch_valid), 32'd0);

      // Fetch accepted in the same cycle load_en rises still responds.
      fetch_req  = 1'b1;
      fetch_addr = 32'h10;
      load_en    = 1'b1;
      step();
      check("ldrise_valid", 32'(fetch_valid), 32'd1);
      check("ldrise_data",  fetch_data, 32'hDEADBE11);
      check("ldrise_busy",  32'(busy), 32'd1);
      fetch_addr = 32'h4;
      check("load_noacc_rdy", 32'(fetch_ready), 32'd0);
      step();
      fetch_req = 1'b0;
      check("load_noacc_val", 32'(fetch_valid), 32'd0);
      check("load_hold_data", fetch_data, 32'hDEADBE11);

      // Reset while in LOAD: asynchronous effect, then CLEAR restarts.
      reset = 1'b1;
      #1;
      check("rst_load_busy",  32'(busy),        32'd1);
      check("rst_load_data",  fetch_data,       32'd0);
      check("rst_load_ready", 32'(fetch_ready), 32'd0);
      step();
      reset   = 1'b0;
      load_en = 1'b0;
      repeat (100) step();
      check("clr100_busy", 32'(busy), 32'd1);

      // Pulse reset at CLEAR cycle 100: full 256-cycle scrub follows.
      reset = 1'b1;
      step();
      reset = 1'b0;
      count_busy(n_busy);
      check("reclear_len", 32'(n_busy), 32'd256);
      do_fetch("scrub10", 32'h10, 32'h0, 1'b0);
      do_fetch("scrub04", 32'h4,  32'h0, 1'b0);

`ifdef IMEM_PARITY_EN
      load_en = 1'b1;
      step();
      ld_write(32'h20, 32'h12345678, 4'b1111);
      load_en = 1'b0;
      step();
      do_fetch("par_ok", 32'h20, 32'h12345678, 1'b0);
      dut.u_ram.par_mem[8][0] = ~dut.u_ram.par_mem[8][0];
      do_fetch("par_bad", 32'h20, 32'h0, 1'b1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_instr_mem
